// File: rtl/fg_pixel_fifo.sv
// -----------------------------------------------------------------------------
// fg_pixel_fifo
//
// Foreground-layer pixel source for the per-channel alpha blenders. An upstream
// memory fetcher pushes 16-bit pixel words into a small FIFO. One word is popped
// for each active pixel (de_i) in step with the vga_core raster counters.
//
// The stream is frame-aligned on a start-of-frame tag carried in bit 15 of each
// word. Underflow (no word available for an active pixel) and misalignment (an
// SOF word reaching the head mid-frame) both drop the block back to searching
// for SOF. Either event sets a sticky error flag.
//
// Word format: {sof[15], alpha[14:12], r[11:8], g[7:4], b[3:0]}
//
// Optional feature macro: FG_FIFO_STATS_EN
//   When it is defined, ufl_cnt_o is a saturating 16-bit underflow counter.
//   When it is undefined, ufl_cnt_o is tied to zero.
//
// Ports
//   clk_i        pixel clock
//   rstn_i       asynchronous active-low reset
//   wr_valid_i   upstream word valid
//   wr_ready_o   FIFO can accept a word (not full)
//   wr_data_i    pixel word
//   hcount_i     raster column
//   vcount_i     raster row
//   de_i         active-video enable
//   fg_r_o/g_o/b_o  registered foreground colour
//   alpha_o      registered foreground alpha
//   de_o         de_i delayed by one cycle, aligned with the colour outputs
//   level_o      FIFO occupancy
//   locked_o     high while the FSM is in RUN (this exposes the FSM state)
//   err_o        sticky underflow/misalignment flag
//   ufl_cnt_o    underflow event count (zero unless FG_FIFO_STATS_EN)
// -----------------------------------------------------------------------------
module fg_pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int HSZ   = 10,
  parameter int VSZ   = 9
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [15:0]                wr_data_i,
  input  logic [HSZ-1:0]             hcount_i,
  input  logic [VSZ-1:0]             vcount_i,
  input  logic                       de_i,
  output logic [3:0]                 fg_r_o,
  output logic [3:0]                 fg_g_o,
  output logic [3:0]                 fg_b_o,
  output logic [2:0]                 alpha_o,
  output logic                       de_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       locked_o,
  output logic                       err_o,
  output logic [15:0]                ufl_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;

  logic        push, pop, out_load, err_set;
  logic        fifo_empty, head_sof, frame_start;
  logic [15:0] head;

  // Write handshake: a word transfers on every rising clock edge where
  // wr_valid_i and wr_ready_o are both high. wr_ready_o depends only on the
  // registered level, never on wr_valid_i. The upstream must hold wr_data_i
  // stable while wr_valid_i is high and wr_ready_o is low.
  assign wr_ready_o  = (level_q != FULL_LVL);
  assign push        = wr_valid_i & wr_ready_o;

  assign fifo_empty  = (level_q == '0);
  assign head        = mem[rd_ptr_q];
  assign head_sof    = head[15];
  assign frame_start = de_i & (hcount_i == '0) & (vcount_i == '0);

  // Storage carries no reset: the pointers and level define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // The level counts only committed writes. This means a word pushed this
  // cycle cannot be popped until the next cycle, so there is no write-to-read
  // bypass.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= WAIT_SOF;
    else         state_q <= state_d;
  end

  // FSM next-state logic and pop decision
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    out_load = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (!fifo_empty) begin
          if (!head_sof) begin
            // Flush stale words from the previous frame, one per cycle.
            pop = 1'b1;
          end else if (frame_start) begin
            pop      = 1'b1;
            out_load = 1'b1;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (de_i) begin
          if (fifo_empty) begin
            err_set = 1'b1;
            state_d = WAIT_SOF;
          end else if (head_sof && !frame_start) begin
            // An SOF word belongs to the next frame. Leave it at the head so
            // that the block relocks on it.
            err_set = 1'b1;
            state_d = WAIT_SOF;
          end else begin
            pop      = 1'b1;
            out_load = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  // Output pixel register. It goes transparent whenever no word was consumed.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fg_r_o  <= '0;
      fg_g_o  <= '0;
      fg_b_o  <= '0;
      alpha_o <= '0;
      de_o    <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      de_o <= de_i;
      if (out_load) begin
        alpha_o <= head[14:12];
        fg_r_o  <= head[11:8];
        fg_g_o  <= head[7:4];
        fg_b_o  <= head[3:0];
      end else begin
        alpha_o <= '0;
        fg_r_o  <= '0;
        fg_g_o  <= '0;
        fg_b_o  <= '0;
      end
      if (err_set) err_o <= 1'b1;
    end
  end

  assign locked_o = (state_q == RUN);
  assign level_o  = level_q;

`ifdef FG_FIFO_STATS_EN
  logic        ufl_evt;
  logic [15:0] ufl_cnt_q;

  assign ufl_evt = (state_q == RUN) & de_i & fifo_empty;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ufl_cnt_q <= '0;
    end else if (ufl_evt && (ufl_cnt_q != 16'hFFFF)) begin
      ufl_cnt_q <= ufl_cnt_q + 16'd1;
    end
  end

  assign ufl_cnt_o = ufl_cnt_q;
`else
  assign ufl_cnt_o = 16'h0000;
`endif

endmodule
